// File: rtl/instr_fetch_loader.sv
// instr_fetch_loader
//   Program memory and fetch stage feeding the control unit. Holds a
//   2**ADDR_W x INSTR_W instruction RAM read by the control unit's address bus,
//   and a byte-serial loader that writes a new program while holding the core
//   in reset. Load stream: header N (0 means 256), then N pairs of
//   {low byte, high byte}; the word written is {high[0], low}.
//
// Ports:
//   Clk                 system clock
//   Rst                 synchronous active-high reset (RAM contents are kept)
//   i_Load_En           level, requests program load mode
//   i_Byte_Valid        one-cycle strobe qualifying i_Byte
//   i_Byte              loader data byte
//   i_Addres_Instr_Bus  fetch address from the control unit
//   o_Instruction       registered fetched instruction (NOP_INSTR unless running)
//   o_Core_Rst          registered reset to the control unit, low only in RUN
//   o_Busy              high while in HDR/LO/HI
//   o_Load_Done         one-cycle pulse after the last word is written
//   o_Load_Count        words written in the current or last load (0..256)
//   o_Err               sticky: malformed high byte or aborted load
module instr_fetch_loader #(
    parameter int unsigned         ADDR_W    = 8,
    parameter int unsigned         INSTR_W   = 9,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               i_Load_En,
    input  logic               i_Byte_Valid,
    input  logic [7:0]         i_Byte,
    input  logic [ADDR_W-1:0]  i_Addres_Instr_Bus,
    output logic [INSTR_W-1:0] o_Instruction,
    output logic               o_Core_Rst,
    output logic               o_Busy,
    output logic               o_Load_Done,
    output logic [ADDR_W:0]    o_Load_Count,
    output logic               o_Err
);

    localparam int unsigned      DEPTH   = 2 ** ADDR_W;
    localparam int unsigned      CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    typedef enum logic [2:0] {StIdle, StHdr, StLo, StHi, StRun, StHalt} state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [CNT_W-1:0]   n_q;
    logic [7:0]         lo_q;
    logic [CNT_W-1:0]   count_inc;
    logic               last_word;
    logic               hdr_take, lo_take, mem_we, abort;
    logic [INSTR_W-1:0] wr_word;

    assign count_inc = o_Load_Count + 1'b1;
    assign last_word = (count_inc == n_q);
    assign wr_word   = INSTR_W'({i_Byte[0], lo_q});

    // Next-state decode; abort (load enable dropped) beats a simultaneous byte.
    always_comb begin
        state_d  = state_q;
        hdr_take = 1'b0;
        lo_take  = 1'b0;
        mem_we   = 1'b0;
        abort    = 1'b0;
        case (state_q)
            StIdle: state_d = i_Load_En ? StHdr : StRun;
            StHdr, StLo, StHi: begin
                if (!i_Load_En) begin
                    abort   = 1'b1;
                    state_d = StHalt;
                end else if (i_Byte_Valid) begin
                    if (state_q == StHdr) begin
                        hdr_take = 1'b1;
                        state_d  = StLo;
                    end else if (state_q == StLo) begin
                        lo_take = 1'b1;
                        state_d = StHi;
                    end else begin
                        mem_we  = 1'b1;
                        state_d = last_word ? StRun : StLo;
                    end
                end
            end
            StRun:   if (i_Load_En) state_d = StHdr;
            StHalt:  if (i_Load_En) state_d = StHdr;
            default: state_d = StIdle;
        endcase
    end

    // RAM has no reset so a program survives Rst.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= wr_word;
        end
    end

    // Outputs are registered from state_d so o_Core_Rst drops and the first
    // fetched word appears in the very first RUN cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= StIdle;
            o_Instruction <= NOP_INSTR;
            o_Core_Rst    <= 1'b1;
            o_Busy        <= 1'b0;
            o_Load_Done   <= 1'b0;
            o_Load_Count  <= '0;
            o_Err         <= 1'b0;
            wr_addr_q     <= '0;
            n_q           <= '0;
            lo_q          <= '0;
        end else begin
            state_q       <= state_d;
            o_Core_Rst    <= (state_d != StRun);
            o_Busy        <= (state_d inside {StHdr, StLo, StHi});
            o_Instruction <= (state_d == StRun) ? mem[i_Addres_Instr_Bus] : NOP_INSTR;
            o_Load_Done   <= mem_we && last_word;

            if (hdr_take) begin
                n_q          <= (i_Byte == 8'h00) ? CNT_MAX : CNT_W'(i_Byte);
                wr_addr_q    <= '0;
                o_Load_Count <= '0;
                o_Err        <= 1'b0;
            end
            if (lo_take) begin
                lo_q <= i_Byte;
            end
            if (mem_we) begin
                wr_addr_q <= wr_addr_q + 1'b1;
                if (o_Load_Count != CNT_MAX) begin
                    o_Load_Count <= count_inc;
                end
                // Only bit 0 of the high byte is meaningful.
                if (|i_Byte[7:1]) begin
                    o_Err <= 1'b1;
                end
            end
            if (abort) begin
                o_Err <= 1'b1;
            end
        end
    end

endmodule
